// File: rtl/types_pkg.sv
// Shared bus widths, multiply/divide operation codes and helper predicates
// used by the iterative multiply/divide unit.
package types_pkg;

  localparam int DATA_BUS      = 32;
  localparam int ADDR_BUS      = 5;
  localparam int MULDIV_CYCLES = 32;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  function automatic logic is_div_op(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

  function automatic logic a_is_signed(input muldiv_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic b_is_signed(input muldiv_op_t op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps on magnitudes, then a sign-fix cycle before done.
//   state | meaning
//   IDLE  | waiting for start; result/rd_out hold last values
//   CALC  | 32 iteration steps, then one sign-correction cycle
//   DONE  | done/we_out high for one cycle, back to IDLE
module mul_div_unit
  import types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [DATA_BUS-1:0] op_a,
  input  logic [DATA_BUS-1:0] op_b,
  input  logic [ADDR_BUS-1:0] rd_in,
  input  logic                kill,
  output logic                busy,
  output logic                done,
  output logic [DATA_BUS-1:0] result,
  output logic [ADDR_BUS-1:0] rd_out,
  output logic                we_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [5:0] CNT_LAST = 6'(MULDIV_CYCLES);

  state_t        state;
  muldiv_op_t    op_q;
  logic [63:0]   acc;
  logic [31:0]   opnd;
  logic [5:0]    cnt;
  logic          neg_q;

  muldiv_op_t    op_in;
  logic          a_neg, b_neg, div_zero, div_ovf;
  logic [31:0]   a_mag, b_mag;
  logic [32:0]   mul_sum;
  logic [33:0]   div_diff;
  logic [63:0]   step_acc, prod;
  logic [31:0]   final_val;

  always_comb begin
    op_in    = muldiv_op_t'(op);
    a_neg    = a_is_signed(op_in) & op_a[31];
    b_neg    = b_is_signed(op_in) & op_b[31];
    a_mag    = a_neg ? (32'd0 - op_a) : op_a;
    b_mag    = b_neg ? (32'd0 - op_b) : op_b;
    div_zero = is_div_op(op_in) && (op_b == 32'd0);
    div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
               (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  end

  // One iteration: shift-add on {hi,lo} for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_diff = {1'b0, acc[63:31]} - {2'b00, opnd};
    step_acc = acc;
    if (is_div_op(op_q)) begin
      if (!div_diff[33]) step_acc = {div_diff[31:0], acc[30:0], 1'b1};
      else               step_acc = {acc[62:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc[31:1]};
    end
  end

  always_comb begin
    prod      = neg_q ? (64'd0 - acc) : acc;
    final_val = prod[31:0];
    case (op_q)
      MUL:                 final_val = prod[31:0];
      MULH, MULHSU, MULHU: final_val = prod[63:32];
      DIV, DIVU:           final_val = neg_q ? (32'd0 - acc[31:0])  : acc[31:0];
      REM, REMU:           final_val = neg_q ? (32'd0 - acc[63:32]) : acc[63:32];
      default:             final_val = prod[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= MUL;
      neg_q  <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op_in;
            rd_out <= rd_in;
            cnt    <= '0;
            acc    <= {32'd0, a_mag};
            opnd   <= b_mag;
            neg_q  <= is_rem_op(op_in) ? a_neg : (a_neg ^ b_neg);
            // Degenerate divides finish without iterating.
            if (div_zero) begin
              result <= is_rem_op(op_in) ? op_a : 32'hFFFF_FFFF;
              done   <= 1'b1;
              state  <= DONE;
            end else if (div_ovf) begin
              result <= is_rem_op(op_in) ? 32'd0 : 32'h8000_0000;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt == CNT_LAST) begin
            result <= final_val;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= step_acc;
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign we_out = done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, randomized
// operations against an arithmetic reference model, kill/reset sequences.
module tb_mul_div_unit;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int passes = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .kill(kill), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      la, lb;
    logic [63:0] p;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    case (o)
      MUL:    begin p = la * lb; return p[31:0]; end
      MULH:   begin p = la * lb; return p[63:32]; end
      MULHSU: begin p = la * longint'({32'd0, b}); return p[63:32]; end
      MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    if (o >= DIV && b == 0) return 1;
    if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input muldiv_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int n;
    @(negedge clk);
    op = o; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    op_a = $urandom();
    op_b = $urandom();
    n = (done === 1'b1) ? 1 : 0;
    while (n == 0 || (done !== 1'b1 && n < 40)) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
    end
    check({name, " latency"}, n, exp_lat);
    check({name, " result"}, result, exp_res);
    check({name, " rd_out"}, rd_out, rd);
    check({name, " we_out"}, we_out, 1'b1);
    @(posedge clk); #1;
    check({name, " done pulse"}, {done, we_out}, 2'b00);
    @(posedge clk); #1;
    check({name, " held"}, {result, rd_out}, {exp_res, rd});
    wait_idle();
  endtask

  vec_t vecs[$];

  initial begin
    int          ndone;
    muldiv_op_t  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rr;

    vecs.push_back('{MUL,    32'd7,          32'd6,          5'd5,  32'd42,         33});
    vecs.push_back('{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'd0,          33});
    vecs.push_back('{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33});
    vecs.push_back('{MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  33});
    vecs.push_back('{DIV,    32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  33});
    vecs.push_back('{REM,    32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33});
    vecs.push_back('{DIVU,   32'd100,        32'd7,          5'd7,  32'd14,         33});
    vecs.push_back('{REMU,   32'd100,        32'd7,          5'd8,  32'd2,          33});
    vecs.push_back('{DIVU,   32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  1});
    vecs.push_back('{REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1});
    vecs.push_back('{DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1});
    vecs.push_back('{REMU,   32'd1234,       32'd0,          5'd0,  32'd1234,       1});
    vecs.push_back('{MUL,    32'hFFFF_FFFD,  32'd5,          5'd12, 32'hFFFF_FFF1,  33});
    vecs.push_back('{DIV,    32'd7,          32'hFFFF_FFFE,  5'd13, 32'hFFFF_FFFD,  33});

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, we_out, result, rd_out}, '0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp_res, vecs[i].exp_lat);

    for (int i = 0; i < 40; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: ra = 32'd0;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom();
      endcase
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        default: rb = $urandom();
      endcase
      rr = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d", i), ro, ra, rb, rr, model(ro, ra, rb), model_lat(ro, ra, rb));
    end

    // start together with kill in IDLE is not accepted
    @(negedge clk);
    op = MUL; op_a = 3; op_b = 4; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    check("start+kill busy", busy, 1'b0);
    start = 1'b0; kill = 1'b0;

    // kill partway through CALC
    @(negedge clk);
    op = MUL; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("kill busy before", busy, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk) kill = 1'b1;
    @(posedge clk); #1;
    check("kill busy after", busy, 1'b0);
    kill = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("kill no done", ndone, 0);
    run_op("after kill", MUL, 32'd11, 32'd13, 5'd21, 32'd143, 33);

    // starts while busy are ignored and produce a single done
    @(negedge clk);
    op = DIVU; op_a = 32'd1000; op_b = 32'd10; rd_in = 5'd14; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = (i == 4 || i == 20 || i == 33);
      op = MUL; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd30;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        check("ignored start result", {result, rd_out}, {32'd100, 5'd14});
      end
      if (i == 33) check("start in DONE ignored", busy, 1'b0);
    end
    check("ignored start done count", ndone, 1);
    wait_idle();

    // reset mid-CALC with start pulses while busy
    @(negedge clk);
    op = MUL; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk) start = (i == 5 || i == 12);
      rd_in = 5'd9;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset outputs", {busy, done, we_out, result, rd_out}, '0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("reset no done", ndone, 0);
    check("reset idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
